fp_addsub_sequencer: RTL and testbench
======================================

// Module: fp_addsub_sequencer
// PURPOSE
//  Multi-cycle controller plus datapath registers for single-precision FP add/subtract.
//  Accepts one operand pair over a valid/ready handshake.
//  Steps it through exponent compare, mantissa align, mantissa add and normalize/pack with a fixed-latency FSM.
//  Returns the result over a second valid/ready handshake.
//  Sits between the FPU top-level issue logic and the result writeback.
// PARAMETERS
//  DATA_WIDTH  32  total float width
//  MENT_WIDTH  23  stored mantissa width (hidden bit added internally -> 24b)
//  EXPO_WIDTH  8   exponent width, bias 2**(EXPO_WIDTH-1)-1
// PORTS
//  clk_in            in   1   clock; all state updates on its rising edge
//  rst_in            in   1   asynchronous, active-high reset
//  abort_in          in   1   synchronous flush of the operation in flight
//  in_valid_in       in   1   operand pair valid
//  in_ready_out      out  1   sequencer idle, can accept operands
//  floating1_in      in   32  operand A
//  floating2_in      in   32  operand B
//  opcode_in         in   1   0 = A+B, 1 = A-B
//  result_valid_out  out  1   result_out valid
//  result_ready_in   in   1   consumer takes the result
//  result_out        out  32  packed IEEE-754 result
//  overflow_out      out  1   result saturated to +/-Inf (valid with result_valid_out)
//  invalid_out       out  1   result is canonical qNaN (valid with result_valid_out)
//  busy_out          out  1   state != IDLE
// BEHAVIOUR
//  - Reset (async): state=IDLE, all datapath regs 0, result_out=0, result_valid_out=0, flags=0,
//    busy_out=0, in_ready_out=1 (in_ready_out = state==IDLE).
//  - FSM: IDLE -> CMP -> ALIGN -> ADD -> NORM -> DONE -> IDLE.
//  - IDLE: on in_valid_in&&in_ready_out, latch operands and opcode, go to CMP.
//  - CMP: effective_sub = sA^sB^opcode. Full magnitude compare on {exp,mant}; larger operand becomes L, other S.
//    exp_diff = expL-expS (unsigned, 8b). Classify special cases: exp==0 -> zero (denormals flushed); exp==all-ones -> Inf/NaN.
//  - ALIGN: mS (24b with hidden bit) >> exp_diff; exp_diff>=25 -> aligned mS=0. Truncate, no guard/round bits.
//  - ADD: 25b sum = mL +/- mS; subtract never negative (L >= S by construction).
//  - NORM: carry set -> shift right 1, exp+1. Otherwise lzc = leading zeros of the 24b sum; shift left lzc, exp-=lzc.
//    sum==0 -> +0 (0x00000000), sign forced positive.
//    exp >= 255 after normalize -> +/-Inf, overflow_out=1.
//    exp <= 0 after normalize -> signed zero (flush).
//    Result sign = sign of L; for effective subtract with B as L, sign = sB^opcode.
//    Special override: any NaN, or Inf-Inf under effective subtract -> 0x7FC00000, invalid_out=1.
//    One Inf -> that Inf with its effective sign. One zero operand -> other operand (with B negated when opcode=1).
//  - DONE: result_valid_out=1; result_out and flags held stable until result_ready_in.
//    On result_ready_in go to IDLE. The next operand accept is no earlier than the following cycle.
//  - Latency: accepting edge E0; result_valid_out rises after edge E4, independent of operand values.
//    Max throughput is 1 op per 6 cycles.
//  - abort_in=1 in any non-IDLE state: next edge -> IDLE, result_valid_out=0, flags=0; no result emitted.
//    abort_in is ignored in IDLE. abort_in has priority over result_ready_in in DONE.
//  - rst_in asserted mid-operation: immediate return to reset values; the in-flight op is lost.
//  - in_valid_in while busy: ignored (no accept); the source holds its data.
// STRUCTURE
//  - fp_addsub_pkg:
//    state encoding (IDLE,CMP,ALIGN,ADD,NORM,DONE as 3b localparams)
//    EXP_MAX=8'hFF, BIAS=127, QNAN=32'h7FC00000, HIDDEN_W=MENT_WIDTH+1
//    field-extract functions (sign/exp/mant)
//  - Sub-module fp_lzc: 24b -> 5b leading-zero counter (priority encoder), purely combinational, used in NORM.
//  - All other logic lives in this module: FSM, stage registers, shifter, adder, pack mux.
// TESTING
//  1. 0x3F800000 + 0x40000000, op=0 -> 0x40000000... result 0x40400000 (3.0); result_valid_out exactly 4 edges after accept.
//  2. 0x40400000 - 0x40400000 (op=1) -> 0x00000000 (+0), overflow_out=0, invalid_out=0.
//  3. 0x3F800000 - 0x40000000 (op=1) -> 0xBF800000 (-1.0); 0xBF800000 + 0x40000000 -> 0x3F800000.
//  4. 0x4B800000 + 0x3F800000 (exp_diff=24, small shifted out) -> 0x4B800000.
//     0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, overflow_out=1.
//  5. 0x7F800000 + 0xFF800000 -> 0x7FC00000, invalid_out=1.
//     0x7FC00001 + 0x3F800000 -> 0x7FC00000, invalid_out=1.
//  6. Hold result_ready_in=0 for 10 cycles -> result_out stable, in_ready_out=0, new in_valid_in not accepted.
//     abort_in in ALIGN -> IDLE next edge with no result_valid_out pulse.
//     rst_in pulse in ADD -> immediate reset values; first op after release completes correctly.

Source files
------------

// File: rtl/fp_addsub_pkg.sv
// Shared constants, state encoding and field helpers for the FP add/sub sequencer.
// No logic of its own; imported by fp_lzc and fp_addsub_sequencer.
// Geometry is IEEE-754 single precision (1 sign, 8 exponent, 23 stored mantissa bits).
package fp_addsub_pkg;

   localparam int DW       = 32;
   localparam int MW       = 23;
   localparam int EW       = 8;
   localparam int HIDDEN_W = MW + 1;

   localparam logic [EW-1:0] EXP_MAX = 8'hFF;
   localparam int            BIAS    = 127;
   localparam logic [DW-1:0] QNAN    = 32'h7FC00000;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_CMP   = 3'd1;
   localparam logic [2:0] ST_ALIGN = 3'd2;
   localparam logic [2:0] ST_ADD   = 3'd3;
   localparam logic [2:0] ST_NORM  = 3'd4;
   localparam logic [2:0] ST_DONE  = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE  = ST_IDLE,
      S_CMP   = ST_CMP,
      S_ALIGN = ST_ALIGN,
      S_ADD   = ST_ADD,
      S_NORM  = ST_NORM,
      S_DONE  = ST_DONE
   } state_t;

   function automatic logic f_sign(input logic [DW-1:0] f);
      return f[DW-1];
   endfunction

   function automatic logic [EW-1:0] f_exp(input logic [DW-1:0] f);
      return f[DW-2:MW];
   endfunction

   function automatic logic [MW-1:0] f_mant(input logic [DW-1:0] f);
      return f[MW-1:0];
   endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter for the 24-bit normalized mantissa sum (priority encoder).
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input.
// Ports: din  - 24-bit value to scan from the MSB
//        cnt  - number of leading zeros, 24 when din is all zeros
module fp_lzc
   import fp_addsub_pkg::*;
(
   input  logic [HIDDEN_W-1:0] din,
   output logic [4:0]          cnt
);

   logic found;

   always_comb begin
      cnt   = 5'(HIDDEN_W);
      found = 1'b0;
      for (int i = HIDDEN_W - 1; i >= 0; i--) begin
         if (!found && din[i]) begin
            cnt   = 5'(HIDDEN_W - 1 - i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fp_addsub_sequencer.sv
// Multi-cycle single-precision FP add/subtract between issue logic and writeback.
// Latency: result_valid_out rises 4 edges after the accepting edge; at most one op per 6 cycles.
// Backpressure: in_ready_out low while busy; result and flags held in DONE until result_ready_in.
// Ports: clk_in/rst_in (async active-high) clock and reset; abort_in flushes the op in flight;
//        in_valid_in/in_ready_out with floating1_in, floating2_in, opcode_in (0 add, 1 sub) for input;
//        result_valid_out/result_ready_in with result_out, overflow_out, invalid_out for output;
//        busy_out high whenever an operation is in progress.
module fp_addsub_sequencer
   import fp_addsub_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int MENT_WIDTH = 23,
   parameter int EXPO_WIDTH = 8
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  abort_in,
   input  logic                  in_valid_in,
   output logic                  in_ready_out,
   input  logic [DATA_WIDTH-1:0] floating1_in,
   input  logic [DATA_WIDTH-1:0] floating2_in,
   input  logic                  opcode_in,
   output logic                  result_valid_out,
   input  logic                  result_ready_in,
   output logic [DATA_WIDTH-1:0] result_out,
   output logic                  overflow_out,
   output logic                  invalid_out,
   output logic                  busy_out
);

   localparam int HW = MENT_WIDTH + 1;
   localparam int NE = EXPO_WIDTH + 2;   // signed exponent width, headroom for +1 and -lzc

   state_t state_q, state_d;

   // operand latch
   logic [DATA_WIDTH-1:0] a_q, b_q;
   logic                  op_q;

   // compare stage
   logic                  eff_sub_q, sign_q;
   logic [EXPO_WIDTH-1:0] exp_l_q, exp_diff_q;
   logic [HW-1:0]         man_l_q, man_s_q;
   logic                  spec_vld_q, spec_inv_q;
   logic [DATA_WIDTH-1:0] spec_res_q;

   // align / add stages
   logic [HW-1:0]         man_s_al_q;
   logic [HW:0]           sum_q;

   // output registers
   logic [DATA_WIDTH-1:0] res_q;
   logic                  ovf_q, inv_q;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d          = state_q;
      in_ready_out     = 1'b0;
      busy_out         = 1'b1;
      result_valid_out = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            in_ready_out = 1'b1;
            busy_out     = 1'b0;
            if (in_valid_in) state_d = S_CMP;
         end
         S_CMP:   state_d = S_ALIGN;
         S_ALIGN: state_d = S_ADD;
         S_ADD:   state_d = S_NORM;
         S_NORM:  state_d = S_DONE;
         S_DONE: begin
            result_valid_out = 1'b1;
            if (result_ready_in) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // abort wins over everything except the idle state, where it is meaningless
      if (abort_in && state_q != S_IDLE) state_d = S_IDLE;
   end

   // ---------------------------------------------------------------- compare / classify
   logic                  sa, sb, a_ge_b, cmp_eff_sub, cmp_sign;
   logic [EXPO_WIDTH-1:0] ea, eb, cmp_exp_l, cmp_exp_s;
   logic [MENT_WIDTH-1:0] ma, mb;
   logic                  a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
   logic                  cmp_spec_vld, cmp_spec_inv;
   logic [DATA_WIDTH-1:0] cmp_spec_res;

   always_comb begin
      sa = f_sign(a_q);
      sb = f_sign(b_q);
      ea = f_exp(a_q);
      eb = f_exp(b_q);
      ma = f_mant(a_q);
      mb = f_mant(b_q);

      // {exp,mant} compares as an unsigned magnitude; ties pick A as the larger
      a_ge_b      = (a_q[DATA_WIDTH-2:0] >= b_q[DATA_WIDTH-2:0]);
      cmp_eff_sub = sa ^ sb ^ op_q;
      cmp_exp_l   = a_ge_b ? ea : eb;
      cmp_exp_s   = a_ge_b ? eb : ea;
      // B contributes with its sign flipped under subtraction
      cmp_sign    = a_ge_b ? sa : (sb ^ op_q);

      a_nan  = (ea == EXP_MAX) && (ma != '0);
      b_nan  = (eb == EXP_MAX) && (mb != '0);
      a_inf  = (ea == EXP_MAX) && (ma == '0);
      b_inf  = (eb == EXP_MAX) && (mb == '0);
      a_zero = (ea == '0);   // denormals are flushed to zero
      b_zero = (eb == '0);

      cmp_spec_vld = 1'b1;
      cmp_spec_inv = 1'b0;
      cmp_spec_res = '0;
      if (a_nan || b_nan) begin
         cmp_spec_res = QNAN;
         cmp_spec_inv = 1'b1;
      end else if (a_inf && b_inf) begin
         if (cmp_eff_sub) begin
            cmp_spec_res = QNAN;
            cmp_spec_inv = 1'b1;
         end else begin
            cmp_spec_res = {sa, EXP_MAX, {MENT_WIDTH{1'b0}}};
         end
      end else if (a_inf) begin
         cmp_spec_res = {sa, EXP_MAX, {MENT_WIDTH{1'b0}}};
      end else if (b_inf) begin
         cmp_spec_res = {sb ^ op_q, EXP_MAX, {MENT_WIDTH{1'b0}}};
      end else if (a_zero && b_zero) begin
         cmp_spec_res = '0;
      end else if (a_zero) begin
         cmp_spec_res = {sb ^ op_q, b_q[DATA_WIDTH-2:0]};
      end else if (b_zero) begin
         cmp_spec_res = a_q;
      end else begin
         cmp_spec_vld = 1'b0;
      end
   end

   // ---------------------------------------------------------------- normalize / pack
   logic [4:0]            lzc;
   logic signed [NE-1:0]  norm_exp;
   logic [MENT_WIDTH-1:0] norm_frac;
   logic [DATA_WIDTH-1:0] norm_res;
   logic                  norm_ovf, norm_inv;

   fp_lzc u_lzc (
      .din (sum_q[HW-1:0]),
      .cnt (lzc)
   );

   always_comb begin
      norm_exp  = '0;
      norm_frac = '0;
      norm_res  = '0;
      norm_ovf  = 1'b0;
      norm_inv  = 1'b0;

      if (sum_q[HW]) begin
         norm_exp  = $signed({2'b00, exp_l_q}) + NE'(1);
         norm_frac = sum_q[HW-1:1];
      end else begin
         norm_exp  = $signed({2'b00, exp_l_q}) - $signed({{(NE-5){1'b0}}, lzc});
         norm_frac = MENT_WIDTH'(sum_q[HW-1:0] << lzc);
      end

      if (spec_vld_q) begin
         norm_res = spec_res_q;
         norm_inv = spec_inv_q;
      end else if (sum_q == '0) begin
         norm_res = '0;   // exact cancellation is always +0
      end else if (norm_exp >= $signed({2'b00, EXP_MAX})) begin
         norm_res = {sign_q, EXP_MAX, {MENT_WIDTH{1'b0}}};
         norm_ovf = 1'b1;
      end else if (norm_exp <= NE'(0)) begin
         norm_res = {sign_q, {(DATA_WIDTH-1){1'b0}}};
      end else begin
         norm_res = {sign_q, norm_exp[EXPO_WIDTH-1:0], norm_frac};
      end
   end

   // ---------------------------------------------------------------- stage registers
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= 1'b0;
         eff_sub_q  <= 1'b0;
         sign_q     <= 1'b0;
         exp_l_q    <= '0;
         exp_diff_q <= '0;
         man_l_q    <= '0;
         man_s_q    <= '0;
         spec_vld_q <= 1'b0;
         spec_inv_q <= 1'b0;
         spec_res_q <= '0;
         man_s_al_q <= '0;
         sum_q      <= '0;
         res_q      <= '0;
         ovf_q      <= 1'b0;
         inv_q      <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (in_valid_in) begin
                  a_q  <= floating1_in;
                  b_q  <= floating2_in;
                  op_q <= opcode_in;
               end
            end
            S_CMP: begin
               eff_sub_q  <= cmp_eff_sub;
               sign_q     <= cmp_sign;
               exp_l_q    <= cmp_exp_l;
               exp_diff_q <= cmp_exp_l - cmp_exp_s;
               man_l_q    <= {1'b1, a_ge_b ? ma : mb};
               man_s_q    <= {1'b1, a_ge_b ? mb : ma};
               spec_vld_q <= cmp_spec_vld;
               spec_inv_q <= cmp_spec_inv;
               spec_res_q <= cmp_spec_res;
            end
            S_ALIGN: begin
               // truncating align; anything shifted 25+ places is gone entirely
               if (exp_diff_q >= EXPO_WIDTH'(HW + 1)) man_s_al_q <= '0;
               else                                   man_s_al_q <= man_s_q >> exp_diff_q;
            end
            S_ADD: begin
               // L >= S in magnitude, so the difference never goes negative
               if (eff_sub_q) sum_q <= {1'b0, man_l_q} - {1'b0, man_s_al_q};
               else           sum_q <= {1'b0, man_l_q} + {1'b0, man_s_al_q};
            end
            S_NORM: begin
               res_q <= norm_res;
               ovf_q <= norm_ovf;
               inv_q <= norm_inv;
            end
            default: ;
         endcase
         if (abort_in && state_q != S_IDLE) begin
            res_q <= '0;
            ovf_q <= 1'b0;
            inv_q <= 1'b0;
         end
      end
   end

   assign result_out   = res_q;
   assign overflow_out = ovf_q;
   assign invalid_out  = inv_q;

endmodule

// File: tb/tb_fp_addsub_sequencer.sv
module tb_fp_addsub_sequencer;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        abort_in;
   logic        in_valid_in;
   logic        in_ready_out;
   logic [31:0] floating1_in;
   logic [31:0] floating2_in;
   logic        opcode_in;
   logic        result_valid_out;
   logic        result_ready_in;
   logic [31:0] result_out;
   logic        overflow_out;
   logic        invalid_out;
   logic        busy_out;

   int checks   = 0;
   int failures = 0;

   always #5 clk_in = ~clk_in;

   fp_addsub_sequencer dut (
      .clk_in           (clk_in),
      .rst_in           (rst_in),
      .abort_in         (abort_in),
      .in_valid_in      (in_valid_in),
      .in_ready_out     (in_ready_out),
      .floating1_in     (floating1_in),
      .floating2_in     (floating2_in),
      .opcode_in        (opcode_in),
      .result_valid_out (result_valid_out),
      .result_ready_in  (result_ready_in),
      .result_out       (result_out),
      .overflow_out     (overflow_out),
      .invalid_out      (invalid_out),
      .busy_out         (busy_out)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        op;
      logic [31:0] res;
      logic        ovf;
      logic        inv;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Issue one op with the consumer always ready; lat counts edges after the accepting edge.
   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic op,
                        output logic [31:0] res, output logic ovf, output logic inv,
                        output int lat);
      @(negedge clk_in);
      chk("accept_ready", {31'd0, in_ready_out}, 32'd1);
      floating1_in    = a;
      floating2_in    = b;
      opcode_in       = op;
      in_valid_in     = 1'b1;
      result_ready_in = 1'b1;
      @(posedge clk_in);
      @(negedge clk_in);
      in_valid_in = 1'b0;
      lat = 0;
      while (!result_valid_out && lat < 20) begin
         @(posedge clk_in);
         @(negedge clk_in);
         lat++;
      end
      res = result_out;
      ovf = overflow_out;
      inv = invalid_out;
   endtask

   initial begin
      logic [31:0] r;
      logic        o, v, seen;
      int          lat;

      vecs[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 1'b0};
      vecs[1]  = '{32'h40400000, 32'h40400000, 1'b1, 32'h00000000, 1'b0, 1'b0};
      vecs[2]  = '{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 1'b0, 1'b0};
      vecs[3]  = '{32'hBF800000, 32'h40000000, 1'b0, 32'h3F800000, 1'b0, 1'b0};
      vecs[4]  = '{32'h4B800000, 32'h3F800000, 1'b0, 32'h4B800000, 1'b0, 1'b0};
      vecs[5]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0};
      vecs[6]  = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 1'b0, 1'b1};
      vecs[7]  = '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b0, 1'b1};
      vecs[8]  = '{32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40400000, 1'b0, 1'b0};
      vecs[9]  = '{32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 1'b0, 1'b0};
      vecs[10] = '{32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 1'b0, 1'b0};
      vecs[11] = '{32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 1'b0, 1'b0};
      vecs[12] = '{32'h3F800000, 32'h00000000, 1'b0, 32'h3F800000, 1'b0, 1'b0};
      vecs[13] = '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 1'b0, 1'b0};
      vecs[14] = '{32'h7F800000, 32'h7F800000, 1'b0, 32'h7F800000, 1'b0, 1'b0};
      vecs[15] = '{32'h40400000, 32'hC0400000, 1'b0, 32'h00000000, 1'b0, 1'b0};

      rst_in          = 1'b1;
      abort_in        = 1'b0;
      in_valid_in     = 1'b0;
      floating1_in    = '0;
      floating2_in    = '0;
      opcode_in       = 1'b0;
      result_ready_in = 1'b1;
      repeat (2) @(negedge clk_in);
      chk("rst_in_ready", {31'd0, in_ready_out}, 32'd1);
      chk("rst_busy", {31'd0, busy_out}, 32'd0);
      chk("rst_valid", {31'd0, result_valid_out}, 32'd0);
      chk("rst_result", result_out, 32'd0);
      chk("rst_flags", {30'd0, overflow_out, invalid_out}, 32'd0);
      rst_in = 1'b0;

      // table-driven vectors
      for (int i = 0; i < 16; i++) begin
         do_op(vecs[i].a, vecs[i].b, vecs[i].op, r, o, v, lat);
         chk($sformatf("vec%0d_latency", i), lat, 32'd4);
         chk($sformatf("vec%0d_result", i), r, vecs[i].res);
         chk($sformatf("vec%0d_overflow", i), {31'd0, o}, {31'd0, vecs[i].ovf});
         chk($sformatf("vec%0d_invalid", i), {31'd0, v}, {31'd0, vecs[i].inv});
      end

      // result held under backpressure; new operands offered meanwhile are not taken
      @(negedge clk_in);
      floating1_in    = 32'h3F800000;
      floating2_in    = 32'h40000000;
      opcode_in       = 1'b0;
      in_valid_in     = 1'b1;
      result_ready_in = 1'b0;
      @(posedge clk_in);
      @(negedge clk_in);
      floating1_in = 32'h41000000;
      lat = 0;
      while (!result_valid_out && lat < 20) begin
         @(posedge clk_in);
         @(negedge clk_in);
         lat++;
      end
      chk("hold_latency", lat, 32'd4);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk_in);
         @(negedge clk_in);
         chk($sformatf("hold%0d_result", i), result_out, 32'h40400000);
         chk($sformatf("hold%0d_vld_rdy", i), {30'd0, result_valid_out, in_ready_out}, 32'd2);
      end
      in_valid_in     = 1'b0;
      result_ready_in = 1'b1;
      @(posedge clk_in);
      @(negedge clk_in);
      chk("hold_release", {30'd0, result_valid_out, in_ready_out}, 32'd1);
      @(posedge clk_in);
      @(negedge clk_in);
      chk("hold_no_accept", {31'd0, busy_out}, 32'd0);

      // reset pulse while in ADD
      @(negedge clk_in);
      floating1_in = 32'h40400000;
      floating2_in = 32'h3F800000;
      in_valid_in  = 1'b1;
      @(posedge clk_in);
      @(negedge clk_in);
      in_valid_in = 1'b0;
      repeat (2) @(negedge clk_in);
      chk("add_busy", {31'd0, busy_out}, 32'd1);
      rst_in = 1'b1;
      #1;
      chk("rst_mid_ready_busy", {30'd0, in_ready_out, busy_out}, 32'd2);
      chk("rst_mid_result", result_out, 32'd0);
      chk("rst_mid_valid", {31'd0, result_valid_out}, 32'd0);
      @(negedge clk_in);
      rst_in = 1'b0;
      do_op(32'h3F800000, 32'h40000000, 1'b0, r, o, v, lat);
      chk("post_rst_latency", lat, 32'd4);
      chk("post_rst_result", r, 32'h40400000);

      // abort while in ALIGN
      @(negedge clk_in);
      floating1_in = 32'h3F800000;
      floating2_in = 32'h40000000;
      in_valid_in  = 1'b1;
      @(posedge clk_in);
      @(negedge clk_in);
      in_valid_in = 1'b0;
      @(negedge clk_in);
      chk("align_busy", {31'd0, busy_out}, 32'd1);
      abort_in = 1'b1;
      @(posedge clk_in);
      @(negedge clk_in);
      abort_in = 1'b0;
      chk("abort_idle", {29'd0, busy_out, in_ready_out, result_valid_out}, 32'd2);
      chk("abort_flags", {30'd0, overflow_out, invalid_out}, 32'd0);
      seen = 1'b0;
      repeat (8) begin
         @(posedge clk_in);
         @(negedge clk_in);
         if (result_valid_out) seen = 1'b1;
      end
      chk("abort_no_result", {31'd0, seen}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
